// File: rtl/weight_register.sv
`default_nettype none
// ============================================================================
// Module      : weight_register
// Description : Single convolution-weight holding register for one processing
//               element.
//
//               The input word is captured on a rising clock edge when the
//               set strobe is high, and is held indefinitely otherwise. The
//               stored weight drives the downstream multiplier continuously.
//               A sticky status flag reports whether any weight has been
//               written since the last reset.
//
// Ports       : WREG_Clk          in   1   clock, rising-edge active
//               WREG_Reset        in   1   asynchronous, active-high reset
//               WREG_Set          in   1   load strobe, sampled at the edge
//               WREG_Input_Data   in   W   weight value to load
//               WREG_Output_Data  out  W   stored weight (register output)
//               WREG_Loaded       out  1   1 once a load occurred since reset
//               WREG_Clear        in   1   synchronous clear (WREG_CLEAR_EN)
//
// Config      : Define macro WREG_CLEAR_EN to add the WREG_Clear input. Clear
//               zeroes the weight and the loaded flag at the next edge and
//               takes priority over Set; asynchronous reset overrides both.
//
// Revision    : 1.0 - initial release
// ============================================================================
module weight_register #(
  parameter int WREG_DATA_WIDTH = 8
) (
  input  logic                       WREG_Clk,
  input  logic                       WREG_Reset,
  input  logic                       WREG_Set,
  input  logic [WREG_DATA_WIDTH-1:0] WREG_Input_Data,
  output logic [WREG_DATA_WIDTH-1:0] WREG_Output_Data,
  output logic                       WREG_Loaded
`ifdef WREG_CLEAR_EN
  ,
  input  logic                       WREG_Clear
`endif
);

  logic [WREG_DATA_WIDTH-1:0] r_weight;
  logic                       r_loaded;

  // Weight and flag share one register process so they can never disagree
  // about whether the current contents came from a load.
  always_ff @(posedge WREG_Clk or posedge WREG_Reset) begin
    if (WREG_Reset) begin
      r_weight <= '0;
      r_loaded <= 1'b0;
    end
`ifdef WREG_CLEAR_EN
    else if (WREG_Clear) begin
      r_weight <= '0;
      r_loaded <= 1'b0;
    end
`endif
    else if (WREG_Set) begin
      r_weight <= WREG_Input_Data;
      r_loaded <= 1'b1;
    end
  end

  // Outputs come straight from flops: no combinational input-to-output path.
  assign WREG_Output_Data = r_weight;
  assign WREG_Loaded      = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_weight_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_register
// Description : Self-checking bench for weight_register (8-bit weight).
//               Table of per-edge vectors plus hand-written sequences for the
//               asynchronous reset pulse, mid-cycle input changes and, when
//               WREG_CLEAR_EN is defined, clear-over-set priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_register;

  localparam int W = 8;

  logic         tb_clk = 1'b0;
  logic         rst;
  logic         set;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         loaded;
`ifdef WREG_CLEAR_EN
  logic         clear;
`endif

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  weight_register #(.WREG_DATA_WIDTH(W)) dut (
    .WREG_Clk         (tb_clk),
    .WREG_Reset       (rst),
    .WREG_Set         (set),
    .WREG_Input_Data  (din),
    .WREG_Output_Data (dout),
    .WREG_Loaded      (loaded)
`ifdef WREG_CLEAR_EN
    ,
    .WREG_Clear       (clear)
`endif
  );

  typedef struct {
    logic         rst;
    logic         set;
    logic [W-1:0] din;
    logic [W-1:0] exp_data;
    logic         exp_loaded;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [W-1:0] exp_data,
                       input logic exp_loaded);
    checks++;
    if (dout !== exp_data || loaded !== exp_loaded) begin
      errors++;
      $display("FAIL %s: got data=%h loaded=%b, expected data=%h loaded=%b",
               name, dout, loaded, exp_data, exp_loaded);
    end
  endtask

  // Drive inputs after the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic step(input logic r, input logic s, input logic [W-1:0] d);
    @(negedge tb_clk);
    rst = r;
    set = s;
    din = d;
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    //            rst   set   din    data   loaded
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0};  // reset dominates set
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h04, 8'h04, 1'b1};  // first load
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h04, 1'b1};  // hold
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h04, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};  // back-to-back max
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};  // then min, flag sticks
    vecs[7]  = '{1'b0, 1'b0, 8'hAA, 8'h00, 1'b1};  // hold ignores data
    vecs[8]  = '{1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h80, 8'h80, 1'b1};  // MSB stored verbatim
    vecs[10] = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b1};

    rst = 1'b1;
    set = 1'b1;
    din = 8'hA5;
`ifdef WREG_CLEAR_EN
    clear = 1'b0;
`endif
    #1;
    check("reset_at_start", 8'h00, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].set, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_loaded);
    end

    // Input changes between edges must not reach the output.
    @(negedge tb_clk);
    set = 1'b1;
    din = 8'h77;
    #1;
    check("no_comb_path", 8'h01, 1'b1);
    @(posedge tb_clk);
    #1;
    check("load_77", 8'h77, 1'b1);

    // Reset pulse between edges clears both outputs before the next edge.
    step(1'b0, 1'b1, 8'h3C);
    check("load_3c", 8'h3C, 1'b1);
    @(negedge tb_clk);
    set = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset_pulse", 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    check("after_pulse_release", 8'h00, 1'b0);
    @(posedge tb_clk);
    #1;
    check("edge_after_release_hold", 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h5A);
    check("edge_after_release_load", 8'h5A, 1'b1);

`ifdef WREG_CLEAR_EN
    step(1'b0, 1'b1, 8'h07);
    check("clr_load_7", 8'h07, 1'b1);
    @(negedge tb_clk);
    clear = 1'b1;
    set   = 1'b1;
    din   = 8'h09;
    @(posedge tb_clk);
    #1;
    check("clear_over_set", 8'h00, 1'b0);
    @(negedge tb_clk);
    clear = 1'b0;
    @(posedge tb_clk);
    #1;
    check("load_after_clear", 8'h09, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
